// File: rtl/b4_dec_scan_if.sv
// Handshake and output bundle of the 4-to-16 decoder/scanner.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface b4_dec_scan_if;
    logic        enable;
    logic [3:0]  binary_in;
    logic        in_valid;
    logic        in_ready;
    logic        scan_mode;
    logic [15:0] decoder_out;
    logic [3:0]  code_out;
    logic        out_valid;
    logic        wrap;

    modport slave (
        input  enable, binary_in, in_valid, scan_mode,
        output in_ready, decoder_out, code_out, out_valid, wrap
    );

    modport master (
        output enable, binary_in, in_valid, scan_mode,
        input  in_ready, decoder_out, code_out, out_valid, wrap
    );
endinterface

// File: rtl/b4_dec_scan.sv
// Registered 4-to-16 one-hot decoder with a hold/auto-scan FSM.
// Each one-hot bit is its own registered lane fed from the next-code path, so decoder_out tracks code_out on the same edge.
module b4_dec_lane #(
    parameter int IDX = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [3:0] i_code,
    output logic       o_q
);
    localparam logic [3:0] LANE = 4'(IDX);

    logic r_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= i_valid && (i_code == LANE);
    end

    assign o_q = r_q;
endmodule

module b4_dec_scan #(
    parameter int SCAN_DIV = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    b4_dec_scan_if.slave  bus
);
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_code;
    logic [3:0]  w_code_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [7:0]  r_div;
    logic [7:0]  w_div_nxt;
    logic        r_wrap;
    logic        w_wrap_nxt;
    logic        r_live;
    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_dec;

    // r_live keeps in_ready low from reset until the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    assign w_ready  = r_live && bus.enable && (r_state == IDLE || r_state == HOLD);
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_code  <= 4'h0;
            r_valid <= 1'b0;
            r_div   <= 8'h00;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_div   <= w_div_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_div_nxt   = r_div;
        w_wrap_nxt  = 1'b0;

        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_code_nxt  = 4'h0;
            w_valid_nxt = 1'b0;
            w_div_nxt   = 8'h00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Scan request wins over a simultaneous transfer.
                    if (bus.scan_mode) begin
                        w_state_nxt = SCAN;
                        w_code_nxt  = 4'h0;
                        w_valid_nxt = 1'b1;
                        w_div_nxt   = 8'h00;
                    end else if (w_accept) begin
                        w_state_nxt = HOLD;
                        w_code_nxt  = bus.binary_in;
                        w_valid_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.scan_mode) begin
                        w_state_nxt = SCAN;
                        w_div_nxt   = 8'h00;
                    end else if (w_accept) begin
                        w_code_nxt  = bus.binary_in;
                    end
                end
                SCAN: begin
                    if (!bus.scan_mode) begin
                        w_state_nxt = HOLD;
                        w_div_nxt   = 8'h00;
                    end else if (r_div >= DIV_LAST) begin
                        w_div_nxt   = 8'h00;
                        w_code_nxt  = r_code + 4'h1;
                        w_wrap_nxt  = (r_code == 4'hF);
                    end else begin
                        w_div_nxt   = r_div + 8'h01;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_code_nxt  = 4'h0;
                    w_valid_nxt = 1'b0;
                    w_div_nxt   = 8'h00;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_lane
        b4_dec_lane #(.IDX(g)) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .i_valid (w_valid_nxt),
            .i_code  (w_code_nxt),
            .o_q     (w_dec[g])
        );
    end

    assign bus.in_ready    = w_ready;
    assign bus.decoder_out = w_dec;
    assign bus.code_out    = r_code;
    assign bus.out_valid   = r_valid;
    assign bus.wrap        = r_wrap;
endmodule

// File: doc/b4_dec_scan.md
B4_DEC_SCAN -- requirements
Module: b4_dec_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per scan step (legal range 1..255).
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port enable, input, 1 bit: block enable; low forces IDLE.
REQ-005 The module SHALL have port binary_in, input, 4 bits: code to decode.
REQ-006 The module SHALL have port in_valid, input, 1 bit: binary_in is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit: code accepted on any edge where in_valid && in_ready.
REQ-008 The module SHALL have port scan_mode, input, 1 bit: request auto-walk through all 16 codes.
REQ-009 The module SHALL have port decoder_out, output, 16 bits: registered one-hot of the current code.
REQ-010 The module SHALL have port code_out, output, 4 bits: registered current code, for loopback into the 16-to-4 encoder.
REQ-011 The module SHALL have port out_valid, output, 1 bit: decoder_out holds a valid one-hot value.
REQ-012 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan advances from 15 to 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HOLD and SCAN.
REQ-014 Transition priority on every edge SHALL be: enable low, then scan_mode, then in_valid.
REQ-015 On any edge with enable=0, the FSM SHALL go to IDLE; on that edge code_out is set to 0, decoder_out to 0, out_valid to 0 and any scan divider is cleared.
REQ-016 In IDLE, in_ready SHALL be 1 when enable=1 and 0 otherwise.
REQ-017 In IDLE with enable=1 and scan_mode=1, the FSM SHALL go to SCAN with code 0 and out_valid=1 on that edge; a simultaneous in_valid is ignored.
REQ-018 In IDLE with enable=1, scan_mode=0 and in_valid=1, the FSM SHALL capture binary_in and go to HOLD, updating code_out, decoder_out and out_valid=1 on that same edge (one-cycle latency).
REQ-019 In HOLD, in_ready SHALL be 1 and every accepted in_valid SHALL replace the code with one-cycle latency; back-to-back transfers are allowed every cycle.
REQ-020 In HOLD with scan_mode=1, the FSM SHALL go to SCAN starting from the current code, with the divider cleared.
REQ-021 In SCAN, in_ready SHALL be 0.
REQ-022 In SCAN, an 8-bit divider SHALL count 0..SCAN_DIV-1; on the edge where it equals SCAN_DIV-1 it returns to 0 and the code increments modulo 16.
REQ-023 On the scan increment from 15 to 0, wrap SHALL be 1 for exactly the following cycle and 0 at all other times.
REQ-024 In SCAN with scan_mode=0, the FSM SHALL go to HOLD keeping the current code, with the divider cleared.
REQ-025 decoder_out SHALL always equal (1 << code_out) when out_valid=1 and 16'h0000 when out_valid=0; it never has more than one bit set.
REQ-026 With SCAN_DIV=1, the code SHALL advance on every edge in SCAN.

Reset
REQ-027 On reset_n low, the block SHALL immediately, without waiting for clock, enter IDLE with decoder_out=0, code_out=0, out_valid=0, wrap=0, in_ready=0 and the divider at 0.
REQ-028 Reset asserted mid-SCAN or mid-HOLD SHALL discard the code; after release, operation restarts from IDLE.
REQ-029 in_ready SHALL become 1 on the first edge after reset_n rises, provided enable=1.

Verification
REQ-030 Directed test, basic decode: reset, enable=1, in_valid=1, binary_in=4'hA for 1 cycle -> next edge: decoder_out=16'h0400, code_out=4'hA, out_valid=1; values held after in_valid drops.
REQ-031 Directed test, streaming: in_valid held for 16 cycles with binary_in = 0..15 -> decoder_out = 16'h0001, 16'h0002, ... 16'h8000 on consecutive edges with no bubbles.
REQ-032 Directed test, scan wrap: SCAN_DIV=4, HOLD at code 14, scan_mode=1 -> code 15 after 4 cycles, then 0 after 4 more cycles with wrap=1 for exactly 1 cycle; in_ready=0 throughout.
REQ-033 Directed test, priority: in IDLE, scan_mode=1, in_valid=1, binary_in=4'h7 -> SCAN from code 0 with decoder_out=16'h0001; binary_in ignored.
REQ-034 Directed test, enable drop: in SCAN at code 5, enable=0 -> next edge: decoder_out=0, out_valid=0; restarting scan begins at 0.
REQ-035 Directed test, reset: reset_n pulsed low between clock edges during SCAN -> all outputs 0 immediately, before the next clock edge; loopback of code_out through the 16-to-4 encoder matches code_out in every earlier test.
